bus_resp_mux: RTL and testbench



---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_timeout_ctr.sv | 37 +++
 rtl/bus_resp_mux.sv | 137 +++++++++++++
 tb/tb_bus_resp_mux.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the system-bus response path.
package bus_pkg;

  typedef enum logic [2:0] {
    RegNone,
    RegMem,
    RegTc,
    RegUart,
    RegGpio
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } bus_state_e;

  localparam logic [31:0] ErrDataDefault = 32'h0000_0000;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating wait-state counter; flags expiry on the last permitted wait cycle.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntLast);

endmodule

// File: rtl/bus_resp_mux.sv
// Bus response mux: decodes chip selects, waits for the selected peripheral, and
// returns a registered ack/rdata/bus_err with decode-error and timeout handling.
module bus_resp_mux
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ErrDataDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic        cs_mem_n,
  input  logic        cs_tc_n,
  input  logic        cs_uart_n,
  input  logic        cs_gpio_n,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] tc_rdata,
  input  logic [31:0] uart_rdata,
  input  logic [31:0] gpio_rdata,
  input  logic        mem_ready,
  input  logic        tc_ready,
  input  logic        uart_ready,
  input  logic        gpio_ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        busy,
  output logic [31:0] err_addr
);

  bus_state_e  state_q;
  region_e     sel_q;
  region_e     dec_region;
  logic        ack_q;
  logic        bus_err_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic [31:0] err_addr_q;
  logic [31:0] addr_q;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        expired;

  // Anything other than exactly one low select decodes to RegNone (error).
  always_comb begin
    dec_region = RegNone;
    case ({cs_gpio_n, cs_uart_n, cs_tc_n, cs_mem_n})
      4'b1110: dec_region = RegMem;
      4'b1101: dec_region = RegTc;
      4'b1011: dec_region = RegUart;
      4'b0111: dec_region = RegGpio;
      default: dec_region = RegNone;
    endcase
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    case (sel_q)
      RegMem:  begin sel_ready = mem_ready;  sel_rdata = mem_rdata;  end
      RegTc:   begin sel_ready = tc_ready;   sel_rdata = tc_rdata;   end
      RegUart: begin sel_ready = uart_ready; sel_rdata = uart_rdata; end
      RegGpio: begin sel_ready = gpio_ready; sel_rdata = gpio_rdata; end
      default: begin sel_ready = 1'b0;       sel_rdata = '0;         end
    endcase
  end

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (state_q == StIdle),
    .en_i      ((state_q == StWait) && !sel_ready),
    .expired_o (expired)
  );

  // ack lags the RESP state by one edge so it is a clean registered pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= RegNone;
      ack_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            if (dec_region != RegNone) begin
              sel_q   <= dec_region;
              addr_q  <= addr;
              we_q    <= we;
              state_q <= StWait;
            end else begin
              rdata_q    <= ERR_DATA;
              bus_err_q  <= 1'b1;
              err_addr_q <= addr;
              state_q    <= StResp;
            end
          end
        end
        StWait: begin
          if (sel_ready) begin
            rdata_q   <= we_q ? 32'h0 : sel_rdata;
            bus_err_q <= 1'b0;
            state_q   <= StResp;
          end else if (expired) begin
            rdata_q    <= ERR_DATA;
            bus_err_q  <= 1'b1;
            err_addr_q <= addr_q;
            state_q    <= StResp;
          end
        end
        StResp: begin
          ack_q   <= 1'b1;
          sel_q   <= RegNone;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
  assign busy     = (state_q != StIdle) || req;

endmodule

// File: tb/tb_bus_resp_mux.sv
// Scoreboard bench for bus_resp_mux: driver pushes expected responses, monitor checks on ack.
module tb_bus_resp_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  csn;
  logic [3:0]  rdy;
  logic        ack;
  logic [31:0] rdata;
  logic        bus_err;
  logic        busy;
  logic [31:0] err_addr;

  localparam logic [31:0] MemData  = 32'h1234_5678;
  localparam logic [31:0] TcData   = 32'hCAFE_0001;
  localparam logic [31:0] UartData = 32'h0000_00A5;
  localparam logic [31:0] GpioData = 32'h0000_0F0F;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_err_addr = 32'h0;

  bus_resp_mux #(
    .TIMEOUT  (16),
    .ERR_DATA (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .cs_mem_n   (csn[0]),
    .cs_tc_n    (csn[1]),
    .cs_uart_n  (csn[2]),
    .cs_gpio_n  (csn[3]),
    .mem_rdata  (MemData),
    .tc_rdata   (TcData),
    .uart_rdata (UartData),
    .gpio_rdata (GpioData),
    .mem_ready  (rdy[0]),
    .tc_ready   (rdy[1]),
    .uart_ready (rdy[2]),
    .gpio_ready (rdy[3]),
    .ack        (ack),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .busy       (busy),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
        chk("err_addr", err_addr, e.eaddr);
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // rsel: index of the peripheral that answers (-1 none); dly: WAIT cycles before ready.
  task automatic txn(input logic [3:0] cs_n, input logic w, input logic [31:0] a,
                     input int rsel, input int dly, input logic [31:0] exp_rdata,
                     input logic exp_err, input int lat);
    exp_t e;
    bit   done;
    int   k;
    @(negedge clk);
    req  = 1'b1;
    we   = w;
    addr = a;
    csn  = cs_n;
    rdy  = 4'h0;
    if (exp_err) exp_err_addr = a;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.eaddr = exp_err_addr;
    e.cyc   = cyc + 1 + lat;
    exp_q.push_back(e);
    done = 1'b0;
    k    = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        done = 1'b1;
        req  = 1'b0;
        rdy  = 4'h0;
        csn  = 4'hF;
        #1 chk("busy_after_ack", {31'h0, busy}, 32'h0);
      end else begin
        if (k == 0) chk("busy_in_txn", {31'h0, busy}, 32'h1);
        rdy = (rsel >= 0 && k >= dly) ? 4'(4'b0001 << rsel) : 4'h0;
      end
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_no_ack: no ack within 100 cycles, expected 1 (addr %h)", a);
      req = 1'b0;
      rdy = 4'h0;
      csn = 4'hF;
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    csn   = 4'hF;
    rdy   = 4'h0;
    #1;
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_bus_err", {31'h0, bus_err}, 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);
    chk("reset_busy_lo", {31'h0, busy}, 32'h0);
    req = 1'b1;
    #1 chk("reset_busy_req", {31'h0, busy}, 32'h1);
    req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    txn(4'b1110, 1'b0, 32'h0000_1000, 0, 0, MemData, 1'b0, 2);
    txn(4'b1011, 1'b0, 32'h2000_0004, 2, 3, UartData, 1'b0, 5);
    txn(4'b1111, 1'b0, 32'h8000_0000, -1, 0, 32'h0, 1'b1, 1);
    txn(4'b0111, 1'b0, 32'h3000_0010, -1, 0, 32'h0, 1'b1, 17);
    txn(4'b1101, 1'b0, 32'h1000_0008, 1, 15, TcData, 1'b0, 17);
    txn(4'b1100, 1'b0, 32'h0000_0040, 0, 0, 32'h0, 1'b1, 1);
    txn(4'b1110, 1'b1, 32'h0000_0044, 0, 1, 32'h0, 1'b0, 3);
    txn(4'b0111, 1'b0, 32'h3000_0000, 3, 0, GpioData, 1'b0, 2);

    // Reset in the middle of a TC wait: no ack, everything clears.
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h1000_0100;
    csn  = 4'b1101;
    rdy  = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    csn   = 4'hF;
    #1;
    chk("midrst_ack", {31'h0, ack}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("midrst_err_addr", err_addr, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_err_addr = 32'h0;
    repeat (4) @(negedge clk);

    txn(4'b1110, 1'b0, 32'h0000_2000, 0, 0, MemData, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
